serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial, LSB-first ripple adder: one full-adder slice (two half-adder stages plus carry OR) and one carry flip-flop, reused over WIDTH clock cycles.
- Sits directly downstream of the half-adder/gate primitives and consumes them: the compact multi-bit add stage for the datapath.
- Operands enter via a valid/ready handshake. The result leaves via a second valid/ready handshake that holds its value under backpressure.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in, captured with operands
- out_valid  output  1  sum/cout hold a completed result (high only in DONE)
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  registered sum, a+b+cin modulo 2^WIDTH
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; in_ready=1 after the edge; out_valid=0; sum=0; cout=0.
  - Shift registers, carry flop and bit counter cleared.
  - Reset overrides every other input, including mid-RUN or DONE. Any in-flight operation is discarded and no result is produced.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- IDLE:
  - On an edge with in_valid=1: capture a into shift register A and b into shift register B, load the carry flop with cin, set count=0, go to RUN.
  - With in_valid=0: remain in IDLE.
- RUN, one bit per edge:
  - s = A[0]^B[0]^carry; c = (A[0]&B[0]) | (carry&(A[0]^B[0])).
  - Shift s into the MSB of the result shift register, shifting right.
  - Shift A and B right by one, load carry with c, increment count.
  - On the edge where count==WIDTH-1: load sum from the completed result register, load cout from the final c, go to DONE.
  - in_valid is ignored throughout RUN.
- Latency: exactly WIDTH cycles from the accepting edge to the edge after which out_valid=1. For WIDTH=8: accept at edge E0, out_valid first seen high after E8.
- DONE:
  - sum and cout stay stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: go to IDLE. out_valid drops and in_ready rises after that edge.
  - in_valid is ignored throughout DONE. There is no operand acceptance on the same edge as the result handshake.
- Throughput: one operation per WIDTH+2 cycles when in_valid and out_ready are held high.
- sum and cout retain the last result in IDLE and RUN. They update only on the RUN→DONE edge or on reset.
- Overflow wraps modulo 2^WIDTH; the carry appears only on cout. No signed interpretation.
- Counter width is $clog2(WIDTH) with a minimum of 1. WIDTH=1 means a single RUN cycle.
- a, b and cin may change freely after the accepting edge without affecting the result.

Test Plan:
- WIDTH=8: rst 2 cycles, then a=0x03, b=0x05, cin=0, in_valid for 1 cycle → out_valid high exactly 8 cycles after accept; sum=0x08, cout=0; in_ready=0 from accept until the result handshake.
- WIDTH=8, carry chain: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Backpressure: result 0x08 ready, out_ready=0 for 5 cycles, in_valid=1 with a=0x10 → out_valid stays 1 and sum stays 0x08; no new accept. Raising out_ready gives IDLE next cycle, then 0x10 is accepted.
- Reset mid-RUN: accept a=0xAA, b=0x55, assert rst at bit 4 → next cycle out_valid=0, sum=0, cout=0, in_ready=1; no result is ever produced. A fresh a=0x01, b=0x01 then yields 0x02.
- Streaming: in_valid and out_ready held high, 4 random operand pairs → accepts spaced exactly WIDTH+2 cycles apart; each result matches the reference a+b+cin.
- WIDTH=1: exhaustive a, b, cin (8 cases) → {cout,sum} equals the 2-bit sum; latency is 1 cycle.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
//   master : producer/consumer side (drives operands, accepts results)
//   slave  : adder side (accepts operands, presents results)
// Signals: in_valid/in_ready/a/b/cin carry operands in; out_valid/out_ready/sum/cout
// carry the registered result out.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice (two half adders plus carry OR) and a
// carry flop reused over WIDTH cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - serial_adder_if.slave: operand handshake in, result handshake out
//          (in_ready high only in IDLE, out_valid high only in DONE)
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Full-adder slice built from two half-adder stages.
  logic ha0_s, ha0_c, ha1_s, ha1_c, bit_c;
  assign ha0_s = a_q[0] ^ b_q[0];
  assign ha0_c = a_q[0] & b_q[0];
  assign ha1_s = ha0_s ^ carry_q;
  assign ha1_c = ha0_s & carry_q;
  assign bit_c = ha0_c | ha1_c;

  // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
  logic [WIDTH-1:0] res_shift;
  assign res_shift = (res_q >> 1) | (WIDTH'(ha1_s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d   = res_shift;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bit_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          sum_d   = res_shift;
          cout_d  = bit_c;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule
